// File: rtl/sobel_3x3.sv
// Streaming 3x3 Sobel edge detector on column beats from an upstream line buffer.
// Fixed 4-edge latency from the sampling edge of a window-valid beat to po_flag.
module sobel_3x3 #(
  parameter int COL_NUM   = 320,
  parameter int THRESHOLD = 40
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] mat_row1,
  input  logic [7:0] mat_row2,
  input  logic [7:0] mat_row3,
  input  logic       mat_flag,
  output logic [7:0] po_data,
  output logic       po_flag
);

  localparam int CW = (COL_NUM > 2) ? $clog2(COL_NUM) : 2;

  logic [CW-1:0] col_cnt_q;
  logic [7:0]    t1_q, t2_q, t3_q, m1_q, m2_q, m3_q, b1_q, b2_q, b3_q;
  logic [9:0]    lft_q, rgt_q, top_q, bot_q;
  logic signed [10:0] gx_q, gy_q;
  logic [10:0]   mag_q;
  logic [3:0]    vld_q;

  logic [9:0]    lft_d, rgt_d, top_d, bot_d;
  logic [10:0]   abs_gx, abs_gy, mag_d;
  logic          win_vld_d;

  // Window is complete only from the third column of a line onward.
  assign win_vld_d = mat_flag && (col_cnt_q >= CW'(2));

  assign lft_d = 10'(t1_q) + (10'(m1_q) << 1) + 10'(b1_q);
  assign rgt_d = 10'(t3_q) + (10'(m3_q) << 1) + 10'(b3_q);
  assign top_d = 10'(t1_q) + (10'(t2_q) << 1) + 10'(t3_q);
  assign bot_d = 10'(b1_q) + (10'(b2_q) << 1) + 10'(b3_q);

  assign abs_gx = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
  assign abs_gy = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
  assign mag_d  = abs_gx + abs_gy;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      t1_q <= '0; t2_q <= '0; t3_q <= '0;
      m1_q <= '0; m2_q <= '0; m3_q <= '0;
      b1_q <= '0; b2_q <= '0; b3_q <= '0;
      lft_q <= '0; rgt_q <= '0; top_q <= '0; bot_q <= '0;
      gx_q <= '0; gy_q <= '0;
      mag_q <= '0;
      vld_q <= '0;
      po_data <= 8'd0;
      po_flag <= 1'b0;
    end else begin
      if (mat_flag) begin
        col_cnt_q <= (col_cnt_q == CW'(COL_NUM - 1)) ? '0 : col_cnt_q + CW'(1);
        t1_q <= t2_q; t2_q <= t3_q; t3_q <= mat_row3;
        m1_q <= m2_q; m2_q <= m3_q; m3_q <= mat_row2;
        b1_q <= b2_q; b2_q <= b3_q; b3_q <= mat_row1;
      end
      lft_q <= lft_d;
      rgt_q <= rgt_d;
      top_q <= top_d;
      bot_q <= bot_d;
      gx_q  <= $signed({1'b0, rgt_q}) - $signed({1'b0, lft_q});
      gy_q  <= $signed({1'b0, bot_q}) - $signed({1'b0, top_q});
      mag_q <= mag_d;
      // Valid rides alongside the data regardless of gaps on mat_flag.
      vld_q <= {vld_q[2:0], win_vld_d};
      po_flag <= vld_q[3];
      if (vld_q[3]) begin
        po_data <= (mag_q > 11'(THRESHOLD)) ? 8'd255 : 8'd0;
      end
    end
  end

endmodule

// File: doc/sobel_3x3.md
SOBEL_3X3 -- requirements
Module: sobel_3x3

Interface
REQ-001 SHALL have parameter COL_NUM, default 320, meaning pixels per line delivered on mat_flag.
REQ-002 SHALL have parameter THRESHOLD, default 40, meaning the edge decision level on gradient magnitude (11-bit unsigned compare).
REQ-003 SHALL have port sclk, input, 1 bit: clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port mat_row1, input, 8 bits: bottom (newest) row pixel of the current column.
REQ-006 SHALL have port mat_row2, input, 8 bits: middle row pixel of the current column.
REQ-007 SHALL have port mat_row3, input, 8 bits: top (oldest) row pixel of the current column.
REQ-008 SHALL have port mat_flag, input, 1 bit: column valid strobe; one column per high cycle; gaps allowed.
REQ-009 SHALL have port po_data, output, 8 bits: edge pixel, 8'd255 = edge, 8'd0 = no edge.
REQ-010 SHALL have port po_flag, output, 1 bit: po_data valid, single-cycle per pixel.

Function
REQ-011 SHALL hold a 3x3 window p[r][c] (r = top/mid/bottom, c = 1 oldest..3 newest); on mat_flag shift c1<=c2<=c3<=new column; hold otherwise.
REQ-012 SHALL count mat_flag beats in col_cnt, 0..COL_NUM-1; wrap to 0 on the beat where col_cnt == COL_NUM-1.
REQ-013 SHALL mark a beat window-valid only when mat_flag = 1 and col_cnt >= 2, so no window straddles two lines; COL_NUM-2 outputs per line.
REQ-014 SHALL compute, pipeline stage 2, signed 11-bit gx = (p_t3 + 2*p_m3 + p_b3) - (p_t1 + 2*p_m1 + p_b1).
REQ-015 SHALL compute, pipeline stage 2, signed 11-bit gy = (p_b1 + 2*p_b2 + p_b3) - (p_t1 + 2*p_t2 + p_t3).
REQ-016 SHALL compute, stage 3, unsigned 11-bit mag = |gx| + |gy| (max 2040, no overflow, no saturation needed).
REQ-017 SHALL register, stage 4, po_data = 8'd255 when mag > THRESHOLD (strictly greater) else 8'd0.
REQ-018 SHALL assert po_flag exactly 4 sclk rising edges after the edge sampling the window-valid mat_flag beat; fixed latency, no stall, no backpressure.
REQ-019 SHALL propagate valid through a 4-deep shift of flags independent of mat_flag gaps; back-to-back beats give back-to-back po_flag.
REQ-020 SHALL hold po_data at its last value while po_flag = 0.
REQ-021 SHALL treat the row count as out of scope: every line is processed; frame-edge rows are the upstream stage's concern.

Reset
REQ-022 SHALL, on rst_n = 0, immediately clear col_cnt, the window, gx, gy, mag, all valid flags, po_data = 8'd0 and po_flag = 0.
REQ-023 SHALL, on reset mid-line, discard in-flight pixels; first mat_flag after release is column 0; first po_flag follows the third beat.

Verification
REQ-024 SHALL pass: constant image, all pixels 100, two lines of COL_NUM=320 -> 318 po_flag per line, all po_data = 0.
REQ-025 SHALL pass: vertical step, columns 0..159 = 0, 160..319 = 255, all rows -> po_data = 255 only for windows centred on columns 159 and 160 (gx = 1020), 0 elsewhere.
REQ-026 SHALL pass: horizontal step, mat_row3 = 0, mat_row2 = mat_row1 = 255 -> every output 255 (gy = 1020).
REQ-027 SHALL pass: threshold boundary, THRESHOLD = 40, left column 0, right column 10, all rows -> mag 40 -> po_data 0; right column 11 -> mag 44 -> po_data 255.
REQ-028 SHALL pass: mat_flag one-in-three cycles, same image as REQ-025 -> identical po_data sequence; each po_flag exactly 4 edges after its valid beat.
REQ-029 SHALL pass: rst_n pulsed low after column 100 -> po_flag = 0 and po_data = 0 during reset; after release, no po_flag until the third mat_flag beat; col_cnt restarts at 0.
